// File: rtl/split_slave.sv
// split_slave: bit-serial memory slave behind an address decoder, with
// optional split transactions. Ports: clk, rstn (async, active-low),
// rx (request in), tx (response out), busy (internal resource busy),
// split_pending (split in progress). Macro SPLIT_SLAVE_SPLIT_EN enables
// the split/resume behaviour; without it a busy access simply stalls.
module split_slave #(
    parameter int                ADDR_W   = 4,
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] MEM_INIT = '0
) (
    input  logic clk,
    input  logic rstn,
    input  logic rx,
    output logic tx,
    input  logic busy,
    output logic split_pending
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W) + 1;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(1);

    localparam logic [1:0] ST_OK = 2'b00;

`ifdef SPLIT_SLAVE_SPLIT_EN
    localparam logic [1:0] ST_SPLIT  = 2'b01;
    localparam logic [1:0] ST_RESUME = 2'b10;

    typedef enum logic [3:0] {
        IDLE, RX_RW, RX_ADDR, RX_DATA, EXEC,
        TX_STAT, TX_DATA, SPLIT_WAIT, RESUME
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, RX_RW, RX_ADDR, RX_DATA, EXEC,
        TX_STAT, TX_DATA
    } state_t;
`endif

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               rw_q, rw_n;
    logic [ADDR_W-1:0]  addr_q, addr_n;
    logic [DATA_W-1:0]  data_q, data_n;
    logic [DATA_W-1:0]  rdata_q, rdata_n;
    logic [1:0]         stat_q, stat_n;
    // Holds off start detection for the first idle cycle after a response.
    logic               gap_q, gap_n;
    logic               do_acc;

    logic [DATA_W-1:0]  mem [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            stat_q  <= ST_OK;
            gap_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rw_q    <= rw_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            rdata_q <= rdata_n;
            stat_q  <= stat_n;
            gap_q   <= gap_n;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= MEM_INIT;
            end
        end else if (do_acc && rw_q) begin
            mem[addr_q] <= data_q;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rw_n    = rw_q;
        addr_n  = addr_q;
        data_n  = data_q;
        rdata_n = rdata_q;
        stat_n  = stat_q;
        gap_n   = 1'b0;
        do_acc  = 1'b0;
        tx      = 1'b1;

        case (state)
            IDLE: begin
                if (!gap_q && !rx) begin
                    state_n = RX_RW;
                end
            end

            RX_RW: begin
                rw_n    = rx;
                cnt_n   = '0;
                state_n = RX_ADDR;
            end

            RX_ADDR: begin
                addr_n = {addr_q[ADDR_W-2:0], rx};
                if (cnt == A_LAST) begin
                    cnt_n   = '0;
                    state_n = rw_q ? RX_DATA : EXEC;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            RX_DATA: begin
                data_n = {data_q[DATA_W-2:0], rx};
                if (cnt == D_LAST) begin
                    cnt_n   = '0;
                    state_n = EXEC;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            EXEC: begin
                if (!busy) begin
                    tx      = 1'b0;
                    do_acc  = 1'b1;
                    rdata_n = mem[addr_q];
                    stat_n  = ST_OK;
                    cnt_n   = '0;
                    state_n = TX_STAT;
                end else begin
`ifdef SPLIT_SLAVE_SPLIT_EN
                    // Request stays latched in rw/addr/data.
                    tx      = 1'b0;
                    stat_n  = ST_SPLIT;
                    cnt_n   = '0;
                    state_n = TX_STAT;
`else
                    tx      = 1'b1;
`endif
                end
            end

            TX_STAT: begin
                tx = cnt[0] ? stat_q[0] : stat_q[1];
                if (cnt == S_LAST) begin
                    cnt_n = '0;
`ifdef SPLIT_SLAVE_SPLIT_EN
                    if (stat_q == ST_SPLIT) begin
                        state_n = SPLIT_WAIT;
                    end else
`endif
                    if (!rw_q) begin
                        state_n = TX_DATA;
                    end else begin
                        state_n = IDLE;
                        gap_n   = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            TX_DATA: begin
                tx      = rdata_q[DATA_W-1];
                rdata_n = {rdata_q[DATA_W-2:0], 1'b0};
                if (cnt == D_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    gap_n   = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

`ifdef SPLIT_SLAVE_SPLIT_EN
            SPLIT_WAIT: begin
                if (!busy) begin
                    do_acc  = 1'b1;
                    rdata_n = mem[addr_q];
                    stat_n  = ST_RESUME;
                    state_n = RESUME;
                end
            end

            RESUME: begin
                tx      = 1'b0;
                cnt_n   = '0;
                state_n = TX_STAT;
            end
`endif

            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef SPLIT_SLAVE_SPLIT_EN
    assign split_pending = (state == SPLIT_WAIT);
`else
    assign split_pending = 1'b0;
`endif

endmodule

// File: doc/split_slave.md
SPLIT_SLAVE -- requirements
Module: split_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning word-address width (memory depth 2**ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 8, meaning data word width.
REQ-003 SHALL have parameter MEM_INIT, default 0, meaning reset value of every memory word.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rx  input  1  serial request line from address decoder, idle high, one bit per clk.
REQ-007 SHALL have port tx  output  1  serial response line to address decoder, idle high, one bit per clk.
REQ-008 SHALL have port busy  input  1  slave-internal resource busy; high at request end forces split.
REQ-009 SHALL have port split_pending  output  1  high while a split transaction awaits completion.

Function
REQ-010 Request frame SHALL be: start bit 0, rw bit (1 = write, 0 = read), ADDR_W address bits MSB first, then DATA_W data bits MSB first for writes only.
REQ-011 Response frame SHALL be: start bit 0, 2-bit status MSB first (00 OK, 01 SPLIT, 10 RESUME), then DATA_W read data bits MSB first only for OK or RESUME of a read.
REQ-012 States SHALL be IDLE, RX_RW, RX_ADDR, RX_DATA, EXEC, TX_STAT, TX_DATA, SPLIT_WAIT, RESUME.
REQ-013 IDLE: rx sampled 0 SHALL go to RX_RW; rx 1 SHALL stay IDLE.
REQ-014 RX_ADDR SHALL count exactly ADDR_W bits; RX_DATA exactly DATA_W bits; read skips RX_DATA.
REQ-015 EXEC (one cycle after last request bit) SHALL sample busy: busy 0 -> perform access, drive tx start bit 0, status OK; busy 1 -> drive start bit, status SPLIT, latch rw/addr/data.
REQ-016 Write SHALL commit to memory in the EXEC cycle when busy is 0; read data SHALL be captured in that same cycle.
REQ-017 Response start bit SHALL appear on tx exactly 1 clk after the last request bit is sampled.
REQ-018 After SPLIT status bits, FSM SHALL enter SPLIT_WAIT with split_pending = 1 and tx = 1.
REQ-019 SPLIT_WAIT: on first cycle busy is 0, SHALL perform latched access and enter RESUME, driving start bit on the next cycle, status 10, then read data if read.
REQ-020 During SPLIT_WAIT, rx traffic SHALL be ignored (no decode, no memory change).
REQ-021 split_pending SHALL drop in the cycle the RESUME start bit is driven.
REQ-022 After final response bit, FSM SHALL return to IDLE with tx = 1; a start bit on rx in that same cycle SHALL be ignored (one idle cycle minimum between frames).
REQ-023 rx sampled while in TX_STAT/TX_DATA SHALL be ignored.
REQ-024 Bit counter SHALL be $clog2(max(ADDR_W,DATA_W))+1 bits; no wrap beyond frame length.

Reset
REQ-025 rstn low SHALL asynchronously force IDLE, tx = 1, split_pending = 0, counters 0, latched request cleared.
REQ-026 Memory SHALL be set to MEM_INIT on reset.
REQ-027 Reset mid-frame or mid-split SHALL abort the transaction with no memory write and no further response bits.

Configuration
REQ-028 Macro SPLIT_SLAVE_SPLIT_EN defined: split behaviour per REQ-015, REQ-018 to REQ-021.
REQ-029 Macro undefined: EXEC SHALL hold tx = 1 while busy is 1, then respond OK on first busy-0 cycle; status SPLIT/RESUME never emitted; split_pending tied 0; states SPLIT_WAIT and RESUME absent.

Verification
REQ-030 Write addr 0x3 data 0xA5, busy 0 -> tx start 1 clk after last bit, status 00, no data; memory[3] = 0xA5.
REQ-031 Read addr 0x3 after REQ-030, busy 0 -> tx 0, 00, 10100101, then idle high.
REQ-032 SPLIT_EN, busy 1, read addr 0x3 -> status 01, split_pending 1; busy low at +20 clk -> next clk start, status 10, data 0xA5; split_pending 0.
REQ-033 SPLIT_EN, busy 1, write 0x7 = 0x3C, second write 0x7 = 0xFF during SPLIT_WAIT, busy low -> RESUME 10; memory[7] = 0x3C.
REQ-034 Reset pulse mid-RX_DATA of write 0x2 = 0x11 -> tx 1, memory[2] = MEM_INIT, next frame decoded normally.
REQ-035 SPLIT_EN undefined, busy 1 for 10 clk, read addr 0x0 -> tx high 10 clk, then start, 00, MEM_INIT data.
